sipo_rx: RTL

- Serial-in, parallel-out receiver: the receive end of the PISO serial link.
- Samples one bit of `sin` per clock while `shift_right` is high, LSB first, matching the PISO right-shift transmit order.
- After WIDTH bits, presents the assembled word on `pout` with a valid/ready handshake.
- Detects overrun and supports aborting a partial word. Sits between the serial line and any parallel consumer.

---
 rtl/serial_pkg.sv | 5 +
 rtl/sipo_shift_core.sv | 30 +++
 rtl/sipo_rx.sv | 41 ++++
 3 files changed

// File: rtl/serial_pkg.sv
// serial_pkg: word-size and bit-order constants shared by the serial link endpoints
package serial_pkg;
  localparam int WIDTH_DEF = 4;
  localparam bit LSB_FIRST = 1'b1;
endpackage

// File: rtl/sipo_shift_core.sv
// sipo_shift_core: LSB-first shift register with bit counter and completion pulse
module sipo_shift_core
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    bit_cnt,
  output logic             done
);
  // bit 0 would only ever be shifted out, so only the upper bits are stored
  logic [WIDTH-1:1] sr;
  assign word = {sin, sr};
  assign done = en && !clear && bit_cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (en) begin
      sr      <= word[WIDTH-1:1];
      bit_cnt <= done ? '0 : bit_cnt + CW'(1);
    end
  end
endmodule

// File: rtl/sipo_rx.sv
// sipo_rx: serial-in parallel-out receiver with valid/ready output and sticky overrun
module sipo_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             shift_right,
  input  logic             clear,
  output logic [WIDTH-1:0] pout,
  output logic             pout_valid,
  input  logic             pout_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overrun
);
  logic [WIDTH-1:0] word;
  logic             done;
  logic             take;
  sipo_shift_core #(.WIDTH(WIDTH), .CW(CW)) u_core (
    .clk(clk), .rst(rst), .sin(sin), .en(shift_right), .clear(clear),
    .word(word), .bit_cnt(bit_cnt), .done(done)
  );
  // a completed word is stored only if the output slot is empty or being drained
  assign take = done && (!pout_valid || pout_ready);
  always_ff @(posedge clk) begin
    if (rst) begin
      pout       <= '0;
      pout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take) pout <= word;
      if (take) pout_valid <= 1'b1;
      else if (pout_valid && pout_ready) pout_valid <= 1'b0;
      if (clear) overrun <= 1'b0;
      else if (done && !take) overrun <= 1'b1;
    end
  end
endmodule
